ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 165 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter (inhibit, request, shift, ack, recover).
// Define PS2TX_TIMEOUT_EN to add a transfer timeout that aborts with an error pulse.
module ps2_host_tx #(
    parameter int INHIBIT = 3600,
    parameter int TIMEOUT = 532000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       ready,
    output logic       done,
    output logic       error,
    input  logic       ps2CkI,
    input  logic       ps2DI,
    output logic       ps2CkO,
    output logic       ps2DO
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INHIBIT = 3'd1;
    localparam logic [2:0] S_REQ     = 3'd2;
    localparam logic [2:0] S_SHIFT   = 3'd3;
    localparam logic [2:0] S_ACK     = 3'd4;
    localparam logic [2:0] S_RECOVER = 3'd5;
    localparam int IW = $clog2(INHIBIT + 1);

    logic [2:0]    state_q, state_d;
    logic [2:0]    ck_s_q, ck_s_d;
    logic [1:0]    d_s_q, d_s_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [3:0]    bit_q, bit_d;
    logic [IW-1:0] inh_q, inh_d;
    logic          nack_q, nack_d;
    logic          ck_o_q, ck_o_d;
    logic          d_o_q, d_o_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          fe;
`ifdef PS2TX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_q, to_d;
`else
    if (TIMEOUT > 0) begin : g_no_timeout
    end
`endif

    // ck_s_q[2] is the previous synchronized level, used only for edge detection
    assign fe     = ck_s_q[2] & ~ck_s_q[1];
    assign ready  = (state_q == S_IDLE);
    assign done   = done_q;
    assign error  = error_q;
    assign ps2CkO = ck_o_q;
    assign ps2DO  = d_o_q;

    always_comb begin
        state_d  = state_q;
        ck_s_d   = {ck_s_q[1:0], ps2CkI};
        d_s_d    = {d_s_q[0], ps2DI};
        shift_d  = shift_q;
        parity_d = parity_q;
        bit_d    = bit_q;
        inh_d    = inh_q;
        nack_d   = nack_q;
        ck_o_d   = ck_o_q;
        d_o_d    = d_o_q;
        done_d   = 1'b0;
        error_d  = 1'b0;
`ifdef PS2TX_TIMEOUT_EN
        to_d     = to_q;
`endif
        case (state_q)
            S_IDLE: if (start) begin
                shift_d  = data;
                parity_d = ~^data;
                bit_d    = 4'd0;
                inh_d    = '0;
                nack_d   = 1'b0;
                ck_o_d   = 1'b1;
                d_o_d    = 1'b0;
                state_d  = S_INHIBIT;
`ifdef PS2TX_TIMEOUT_EN
                to_d     = '0;
`endif
            end
            S_INHIBIT: if (inh_q == IW'(INHIBIT - 1)) begin
                state_d = S_REQ;
                ck_o_d  = 1'b0;
                d_o_d   = 1'b1;
            end else begin
                inh_d = inh_q + IW'(1);
            end
            S_REQ: if (fe) begin
                state_d = S_SHIFT;
                d_o_d   = ~shift_q[0];
            end
            // bit_q counts bits already placed; the next one is bit_q+1 (8 = parity, 9 = stop)
            S_SHIFT: if (fe) begin
                if (bit_q == 4'd9) begin
                    state_d = S_ACK;
                    nack_d  = d_s_q[1];
                end else begin
                    bit_d = bit_q + 4'd1;
                    d_o_d = (bit_q == 4'd8) ? 1'b0 :
                            (bit_q == 4'd7) ? ~parity_q : ~shift_q[bit_q[2:0] + 3'd1];
                end
            end
            S_ACK: state_d = S_RECOVER;
            S_RECOVER: if (ck_s_q[1] & d_s_q[1]) begin
                state_d = S_IDLE;
                done_d  = ~nack_q;
                error_d = nack_q;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef PS2TX_TIMEOUT_EN
        if (state_q != S_IDLE && state_q != S_INHIBIT) begin
            to_d = to_q + TW'(1);
            if (to_q == TW'(TIMEOUT - 1)) begin
                state_d = S_IDLE;
                ck_o_d  = 1'b0;
                d_o_d   = 1'b0;
                done_d  = 1'b0;
                error_d = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ck_s_q   <= '1;
            d_s_q    <= '1;
            shift_q  <= '0;
            parity_q <= 1'b0;
            bit_q    <= '0;
            inh_q    <= '0;
            nack_q   <= 1'b0;
            ck_o_q   <= 1'b0;
            d_o_q    <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
`ifdef PS2TX_TIMEOUT_EN
            to_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ck_s_q   <= ck_s_d;
            d_s_q    <= d_s_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            bit_q    <= bit_d;
            inh_q    <= inh_d;
            nack_q   <= nack_d;
            ck_o_q   <= ck_o_d;
            d_o_q    <= d_o_d;
            done_q   <= done_d;
            error_q  <= error_d;
`ifdef PS2TX_TIMEOUT_EN
            to_q     <= to_d;
`endif
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a simple PS/2 device model (40-cycle clock).
module tb_ps2_host_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, ready, done, error, ps2CkO, ps2DO;
    logic [7:0] data;
    logic dev_ck = 1'b1, dev_d = 1'b1;
    logic ck_line, d_line;
    assign ck_line = ~ps2CkO & dev_ck;
    assign d_line  = ~ps2DO & dev_d;

    int n_cmp = 0, n_bad = 0;
    int n_done = 0, n_err = 0, n_both = 0;

    ps2_host_tx #(.INHIBIT(20), .TIMEOUT(2000)) dut (
        .clock(clk), .reset(reset), .start(start), .data(data),
        .ready(ready), .done(done), .error(error),
        .ps2CkI(ck_line), .ps2DI(d_line), .ps2CkO(ps2CkO), .ps2DO(ps2DO)
    );

    always @(negedge clk) begin
        if (done) n_done <= n_done + 1;
        if (error) n_err <= n_err + 1;
        if (done && error) n_both <= n_both + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input logic [7:0] b);
        data = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Device side: measures inhibit, samples the data line on every rising clock-line edge,
    // optionally answers ACK, or stops after abort_at falling edges.
    task automatic dev_xfer(input bit ack, input int abort_at, output logic [10:0] bits, output int inh);
        int n;
        bits = '0;
        inh = 0;
        n = 0;
        while (ps2CkO && n < 1000) begin
            inh++;
            n++;
            @(negedge clk);
        end
        bits[0] = d_line;
        repeat (20) @(negedge clk);
        for (int p = 1; p <= 11; p++) begin
            dev_ck = 1'b0;
            if (p == abort_at) begin
                repeat (10) @(negedge clk);
                return;
            end
            repeat (20) @(negedge clk);
            dev_ck = 1'b1;
            if (p <= 10) bits[p] = d_line;
            repeat (10) @(negedge clk);
            if (p == 10 && ack) dev_d = 1'b0;
            repeat (10) @(negedge clk);
        end
        dev_d = 1'b1;
    endtask

    logic [10:0] bits;
    int inh, d0, e0, n;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        data = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outputs", {ready, ps2CkO, ps2DO, done, error}, 5'b10000);
        reset = 1'b0;
        @(negedge clk);

        d0 = n_done; e0 = n_err;
        pulse_start(8'hED);
        fork
            dev_xfer(1'b1, 0, bits, inh);
            begin
                repeat (100) @(negedge clk);
                check("busy_ready", ready, 0);
                pulse_start(8'h55);
            end
        join
        check("ed_inhibit", inh, 20);
        check("ed_bits", bits, 11'b1_1_11101101_0);
        repeat (10) @(negedge clk);
        check("ed_done", n_done - d0, 1);
        check("ed_err", n_err - e0, 0);
        check("ed_ready", ready, 1);

        d0 = n_done; e0 = n_err;
        pulse_start(8'h07);
        dev_xfer(1'b1, 0, bits, inh);
        repeat (10) @(negedge clk);
        check("x07_bits", bits, 11'b1_0_00000111_0);
        check("x07_done", n_done - d0, 1);
        check("x07_err", n_err - e0, 0);

        d0 = n_done; e0 = n_err;
        pulse_start(8'h3C);
        dev_xfer(1'b0, 0, bits, inh);
        repeat (10) @(negedge clk);
        check("nack_bits", bits, 11'b1_1_00111100_0);
        check("nack_err", n_err - e0, 1);
        check("nack_done", n_done - d0, 0);
        check("nack_ready", ready, 1);

        d0 = n_done; e0 = n_err;
        pulse_start(8'hA5);
        dev_xfer(1'b1, 4, bits, inh);
        check("abort_pre", {ps2CkO, ps2DO, ready}, 3'b010);
        reset = 1'b1;
        @(negedge clk);
        check("abort_reset", {ps2CkO, ps2DO, ready, done, error}, 5'b00100);
        reset = 1'b0;
        dev_ck = 1'b1;
        dev_d = 1'b1;
        repeat (50) @(negedge clk);
        check("abort_pulses", {n_done - d0, n_err - e0}, 0);
        pulse_start(8'hF4);
        dev_xfer(1'b1, 0, bits, inh);
        repeat (10) @(negedge clk);
        check("f4_bits", bits, 11'b1_0_11110100_0);
        check("f4_done", n_done - d0, 1);
        check("f4_err", n_err - e0, 0);

        d0 = n_done; e0 = n_err;
        pulse_start(8'h12);
        n = 0;
        while (ps2CkO && n < 1000) begin
            n++;
            @(negedge clk);
        end
`ifdef PS2TX_TIMEOUT_EN
        n = 0;
        while (!error && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("to_cycles", n, 2000);
        check("to_lines", {ps2CkO, ps2DO, ready}, 3'b001);
        repeat (5) @(negedge clk);
        check("to_err", n_err - e0, 1);
`else
        repeat (3000) @(negedge clk);
        check("noto_ready", ready, 0);
        check("noto_lines", {ps2CkO, ps2DO}, 2'b01);
        check("noto_err", n_err - e0, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
`endif
        check("to_done", n_done - d0, 0);
        check("never_both", n_both, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
